// File: rtl/mips_pkg.sv
// Shared MIPS-I datapath constants and writeback bundle types.
// Opcodes here select the load aligner behaviour in writeback.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_trace_t;

endpackage

// File: rtl/load_ext.sv
// Load data aligner: picks the addressed byte/half of a memory word
// and sign- or zero-extends it according to the load opcode.
module load_ext
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  dal,
    input  logic [31:0] lrwd,
    output logic [31:0] ext
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = lrwd[7:0];
        unique case (dal)
            2'd0: b = lrwd[7:0];
            2'd1: b = lrwd[15:8];
            2'd2: b = lrwd[23:16];
            2'd3: b = lrwd[31:24];
        endcase
    end

    // dal[0] is deliberately ignored for halfwords
    assign h = dal[1] ? lrwd[31:16] : lrwd[15:0];

    always_comb begin
        ext = lrwd;
        case (op)
            OP_LB:   ext = {{24{b[7]}}, b};
            OP_LBU:  ext = {24'd0, b};
            OP_LH:   ext = {{16{h[15]}}, h};
            OP_LHU:  ext = {16'd0, h};
            OP_LW:   ext = lrwd;
            default: ext = lrwd;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 31-entry GPR file with write-through bypass,
// retired-instruction counter and registered writeback trace.
module wb_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic [4:0]  rwa,
    input  logic [31:0] lres,
    input  logic [1:0]  dal,
    input  logic        ltn,
    input  logic [31:0] lrwd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic [31:0] instret
);

    logic [31:0] gpr [31:1];
    logic [31:0] ext;
    logic [31:0] wd;
    logic        we;
    logic [31:0] cnt_q;
    wb_trace_t   tr_q;

    load_ext u_load_ext (
        .op   (ins[31:26]),
        .dal  (dal),
        .lrwd (lrwd),
        .ext  (ext)
    );

    assign wd = ltn ? ext : lres;
    assign we = (rwa != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (we) begin
            gpr[rwa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (ins != 32'd0) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tr_q <= '0;
        end else begin
            tr_q.we   <= we;
            tr_q.addr <= rwa;
            tr_q.data <= wd;
            tr_q.pc   <= pc;
        end
    end

    // Bypass is suppressed during reset so reads are 0 that cycle
    always_comb begin
        rd1 = '0;
        if (!reset && ra1 != 5'd0) begin
            rd1 = (we && ra1 == rwa) ? wd : gpr[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (!reset && ra2 != 5'd0) begin
            rd2 = (we && ra2 == rwa) ? wd : gpr[ra2];
        end
    end

    assign wb_we   = tr_q.we;
    assign wb_addr = tr_q.addr;
    assign wb_data = tr_q.data;
    assign wb_pc   = tr_q.pc;
    assign instret = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks followed by random
// traffic compared each cycle against a behavioural register model.
module tb_wb_regfile;

    logic        clk = 0;
    logic        reset;
    logic [31:0] pc, ins, lres, lrwd;
    logic [4:0]  rwa, ra1, ra2;
    logic [1:0]  dal;
    logic        ltn;
    logic [31:0] rd1, rd2, wb_data, wb_pc, instret;
    logic        wb_we;
    logic [4:0]  wb_addr;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_cnt;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_pc;

    wb_regfile dut (
        .clk(clk), .reset(reset), .pc(pc), .ins(ins), .rwa(rwa),
        .lres(lres), .dal(dal), .ltn(ltn), .lrwd(lrwd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_pc(wb_pc), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_ext(logic [5:0] op, logic [1:0] a,
                                          logic [31:0] w);
        logic [31:0] bs, hs;
        logic [7:0]  bv;
        logic [15:0] hv;
        bs = w >> (8 * a);
        hs = w >> (16 * a[1]);
        bv = bs[7:0];
        hv = hs[15:0];
        case (op)
            6'h20:   return 32'($signed(bv));
            6'h24:   return 32'(bv);
            6'h21:   return 32'($signed(hv));
            6'h25:   return 32'(hv);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_wd();
        return ltn ? m_ext(ins[31:26], dal, lrwd) : lres;
    endfunction

    function automatic logic [31:0] m_rd(logic [4:0] a);
        if (reset || a == 0) return 0;
        if (rwa != 0 && a == rwa) return m_wd();
        return m_gpr[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_gpr[i] <= 0;
            m_cnt <= 0;
            m_we <= 0;
            m_addr <= 0;
            m_data <= 0;
            m_pc <= 0;
        end else begin
            if (rwa != 0) m_gpr[rwa] <= m_wd();
            if (ins != 0) m_cnt <= m_cnt + 1;
            m_we <= (rwa != 0);
            m_addr <= rwa;
            m_data <= m_wd();
            m_pc <= pc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd1", rd1, m_rd(ra1));
            chk("rd2", rd2, m_rd(ra2));
            chk("wb_we", 32'(wb_we), 32'(m_we));
            chk("wb_addr", 32'(wb_addr), 32'(m_addr));
            chk("wb_data", wb_data, m_data);
            chk("wb_pc", wb_pc, m_pc);
            chk("instret", instret, m_cnt);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic low();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        ins = 0; rwa = 0; ltn = 0; lres = 0; dal = 0;
        lrwd = 0; pc = 0; reset = 0;
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] lexp [5];
        logic [5:0]  lop [5];
        logic [1:0]  ldal [5];
        ops = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h00};
        lop = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
        ldal = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
        lexp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                 32'h00007F01, 32'h80FF7F01};

        idle();
        ra1 = 0; ra2 = 0; reset = 1;
        nxt();
        reset = 0;
        chk_en = 1;

        for (int i = 0; i < 5; i++)
            chk("model_ext", m_ext(lop[i], ldal[i], 32'h80FF7F01), lexp[i]);

        low();
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1;
            chk("reset_rd", rd1, 0);
        end
        chk("reset_instret", instret, 0);
        chk("reset_wb_we", 32'(wb_we), 0);

        nxt();
        ins = 32'h00221820; rwa = 3; ltn = 0; lres = 32'hDEADBEEF;
        ra1 = 3; pc = 32'h400;
        low();
        chk("alu_bypass", rd1, 32'hDEADBEEF);
        nxt();
        idle();
        low();
        chk("alu_array", rd1, 32'hDEADBEEF);
        chk("alu_wb_we", 32'(wb_we), 1);
        chk("alu_wb_addr", 32'(wb_addr), 3);

        for (int i = 0; i < 5; i++) begin
            nxt();
            ins = {lop[i], 26'h1}; rwa = 5; ltn = 1;
            lrwd = 32'h80FF7F01; dal = ldal[i]; ra1 = 5; ra2 = 5;
            low();
            chk("load_rd1", rd1, lexp[i]);
            chk("load_rd2", rd2, lexp[i]);
        end

        nxt();
        idle();
        ins = 32'h1; rwa = 0; lres = 32'h12345678; ra1 = 0;
        low();
        chk("r0_same", rd1, 0);
        nxt();
        idle();
        low();
        chk("r0_after", rd1, 0);
        chk("r0_wb_we", 32'(wb_we), 0);

        nxt();
        reset = 1;
        for (int i = 0; i < 8; i++) begin
            nxt();
            idle();
            ins = (i inside {1, 4, 6}) ? 0 : 32'h100 + i;
        end
        nxt();
        idle();
        low();
        chk("count5", instret, 5);

        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        nxt();
        ins = 32'h1;
        nxt();
        idle();
        low();
        chk("count_wrap", instret, 0);

        nxt();
        ins = 32'h5; rwa = 7; lres = 32'hAA; reset = 1;
        nxt();
        idle();
        ra1 = 7;
        low();
        chk("midreset_r7", rd1, 0);
        chk("midreset_cnt", instret, 0);

        for (int c = 0; c < 3000; c++) begin
            nxt();
            reset = ($urandom_range(0, 59) == 0);
            ins = ($urandom_range(0, 3) == 0) ? 0 :
                  {ops[$urandom_range(0, 5)], 26'($urandom)};
            rwa = 5'($urandom);
            ltn = 1'($urandom);
            lres = $urandom;
            lrwd = $urandom;
            dal = 2'($urandom);
            pc = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom);
        end

        nxt();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and general-purpose register file for the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, aligns and extends load data, writes the selected GPR, and serves two combinational read ports to decode with write-through bypass. It also keeps a retired-instruction counter and a registered writeback trace for the testbench.

## Interface
Parameters:
- none; widths are fixed by the MIPS-I datapath.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `pc` in 32: PC of the instruction in WB.
- `ins` in 32: instruction word in WB; 0 denotes a bubble.
- `rwa` in 5: destination GPR index; 0 means no write.
- `lres` in 32: ALU/link result.
- `dal` in 2: byte offset, i.e. address[1:0], of the memory access.
- `ltn` in 1: 1 means the result comes from memory (`lrwd`), 0 means `lres`.
- `lrwd` in 32: raw word read from data memory.
- `ra1`, `ra2` in 5: read addresses from decode.
- `rd1`, `rd2` out 32: read data, combinational.
- `wb_we` out 1, `wb_addr` out 5, `wb_data` out 32, `wb_pc` out 32: registered trace of the previous cycle's GPR write.
- `instret` out 32: count of retired non-bubble instructions.

## Operation
- Load select uses `ins[31:26]` when `ltn=1`:
  - 0x20 lb: sign-extend byte `dal`.
  - 0x24 lbu: zero-extend byte `dal`.
  - 0x21 lh: sign-extend half `dal[1]`.
  - 0x25 lhu: zero-extend half `dal[1]`.
  - 0x23 lw: full word, `dal` ignored.
  - Any other opcode: full word unmodified.
- Byte lane numbering is little-endian: byte k = `lrwd[8k+7:8k]`; half h = `lrwd[16h+15:16h]`.
- Misaligned halfword (`dal[0]=1`): `dal[0]` is ignored; no exception is raised.
- Write data `wd = ltn ? extended(lrwd) : lres`.
- Write enable `we = (rwa != 0)`. Register 0 always reads 0 and is never stored.
- Read port n: `rdn = (ran == 0) ? 0 : (we && ran == rwa) ? wd : gpr[ran]`. This is same-cycle write-through bypass.
- `instret` increments by 1 on each edge where `ins != 0`, independent of `we`. It wraps from 0xFFFFFFFF to 0.

## Timing
- GPR write occurs on the rising edge at which WB presents the instruction.
  - The value is visible combinationally via bypass in that same cycle.
  - It is visible from the array the following cycle.
- Trace outputs lag by exactly one cycle: `wb_we<=we`, `wb_addr<=rwa`, `wb_data<=wd`, `wb_pc<=pc`.
- Reset (synchronous, takes priority over everything):
  - All 31 GPRs become 0, as do `instret`, `wb_we`, `wb_addr`, `wb_data` and `wb_pc`.
  - A write presented in the reset cycle is discarded. Bypass is suppressed while `reset=1`, so reads return 0.
- Reset asserted mid-stream: on the first cycle after deassertion, all reads return 0 and `instret`=0.
- Both read ports may address the write target simultaneously; both get `wd`.

## Structure
- Shared package `mips_pkg` holds opcode constants: `OP_LB`, `OP_LBU`, `OP_LH`, `OP_LHU`, `OP_LW`.
- One natural sub-module: `load_ext`, a combinational aligner/extender with inputs `op`, `dal`, `lrwd` and output `ext`.
- The array is 31 registers (1..31) in flops; no SRAM inference is required.

## Test plan
- Reset: after 1 reset cycle, read all 32 addresses -> all 0; `instret`=0; `wb_we`=0.
- ALU write: `ins`=0x00221820, `rwa`=3, `ltn`=0, `lres`=0xDEADBEEF.
  - Same cycle: `ra1`=3 gives `rd1`=0xDEADBEEF (bypass).
  - Next cycle: array read gives 0xDEADBEEF; `wb_we`=1, `wb_addr`=3.
- Loads with `lrwd`=0x80FF7F01:
  - lb `dal`=3 -> 0xFFFFFF80; lbu `dal`=3 -> 0x00000080.
  - lh `dal`=2 -> 0xFFFF80FF; lhu `dal`=0 -> 0x00007F01; lw -> 0x80FF7F01.
- $0 protection: `rwa`=0, `lres`=0x12345678 -> `rd1`(`ra1`=0)=0 that cycle and after; `wb_we`=0.
- Counter: 5 instructions interleaved with 3 bubbles (`ins`=0) -> `instret`=5.
  - Preload `instret` to 0xFFFFFFFF, then retire 1 -> `instret`=0.
- Reset mid-stream: assert `reset` during a write to r7 with 0xAA -> r7 reads 0 afterward; `instret`=0.
